// File: rtl/axis_qam_mapper.sv
// -----------------------------------------------------------------------------
// axis_qam_mapper
//
// Purpose:
//   Takes a packed MSB-first bit stream and maps it onto the positive
//   subcarriers 1..NFFT/2-1 of one OFDM frame, using QPSK or Gray-coded
//   16-QAM. The negative subcarriers are filled with the complex conjugates
//   (Hermitian symmetry), so an IFFT of the frame gives a real time signal.
//   Bins 0 (DC) and NFFT/2 (Nyquist) are always zero. The frame is then
//   streamed out as NFFT complex samples.
//
// Parameters:
//   NFFT  FFT size, power of two, 16..256
//   AMP   unit constellation amplitude, signed 16-bit (3*AMP < 32768)
//
// Ports:
//   aclk, aresetn      clock; synchronous active-low reset
//   s_axis_*           input bit stream, 32-bit words, MSB first
//   m_axis_*           output subcarriers, tdata = {I[31:16], Q[15:0]}
//   en                 global enable; low freezes all state
//   mode               0 = QPSK (2 b/sym), 1 = 16-QAM (4 b/sym); latched
//                      on the first word of each frame
//   err                sticky framing error (tlast misplaced on input)
//
// Build option:
//   AXIS_QAM_ERR_EN    when defined, s_axis_tlast is checked against the
//                      frame word count and err is set on a mismatch.
//                      When undefined, tlast is ignored and err is 0.
// -----------------------------------------------------------------------------
module axis_qam_mapper #(
  parameter int                 NFFT = 64,
  parameter logic signed [15:0] AMP  = 16'sh2000
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  input  logic        en,
  input  logic        mode,
  output logic        err
);

  // Symbols per frame and words per frame for each modulation.
  localparam int NSYM     = NFFT / 2 - 1;
  localparam int WPF_QAM  = (NSYM * 4 + 31) / 32;
  localparam int WPF_QPSK = (NSYM * 2 + 31) / 32;
  localparam int BUFW     = WPF_QAM * 32;
  localparam int IDXW     = $clog2(NFFT);
  localparam int WCW      = $clog2(WPF_QAM + 1);
  localparam int SCW      = $clog2(NSYM + 1);

  // Constellation levels in 16-bit two's complement (wrap, no saturation).
  localparam logic [15:0] AMP_P1 = AMP;
  localparam logic [15:0] AMP_P3 = AMP_P1 + AMP_P1 + AMP_P1;
  localparam logic [15:0] AMP_N1 = 16'd0 - AMP_P1;
  localparam logic [15:0] AMP_N3 = 16'd0 - AMP_P3;

  typedef enum logic [1:0] {
    S_READ  = 2'd0,
    S_MAP   = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [WCW-1:0]    word_cnt_r;
  logic              mode_r;
  logic [SCW-1:0]    sym_cnt_r;
  logic [IDXW-1:0]   out_idx_r;
  logic [BUFW-1:0]   bits_r;
  logic [31:0]       mem_r [NFFT];
  logic [31:0]       m_tdata_r;
  logic              m_tvalid_r;
  logic              m_tlast_r;

  logic              s_hs_s;
  logic              m_hs_s;
  logic              mode_eff_s;
  logic [WCW-1:0]    wpf_s;
  logic              last_word_s;
  logic              last_sym_s;
  logic              last_bin_s;
  logic [IDXW-1:0]   nxt_idx_s;
  logic [31:0]       bin_data_s;
  logic [3:0]        sym_bits_s;
  logic [15:0]       sym_i_s;
  logic [15:0]       sym_q_s;
  logic [15:0]       sym_qn_s;
  logic [IDXW-1:0]   sym_idx_s;
  logic [IDXW-1:0]   conj_idx_s;

  // Gray-coded 16-QAM axis level: 00 -> -3, 01 -> -1, 11 -> +1, 10 -> +3.
  function automatic logic [15:0] gray_level(input logic [1:0] b);
    logic [15:0] lvl;
    case (b)
      2'b00:   lvl = AMP_N3;
      2'b01:   lvl = AMP_N1;
      2'b11:   lvl = AMP_P1;
      2'b10:   lvl = AMP_P3;
      default: lvl = 16'd0;
    endcase
    return lvl;
  endfunction

  // QPSK axis level: 0 -> +AMP, 1 -> -AMP.
  function automatic logic [15:0] qpsk_level(input logic b);
    logic [15:0] lvl;
    if (b) begin
      lvl = AMP_N1;
    end else begin
      lvl = AMP_P1;
    end
    return lvl;
  endfunction

  assign s_axis_tready = aresetn & en & (state_r == S_READ);
  assign s_hs_s        = s_axis_tvalid & s_axis_tready;
  assign m_hs_s        = en & m_tvalid_r & m_axis_tready;

  assign m_axis_tdata  = m_tdata_r;
  assign m_axis_tvalid = m_tvalid_r;
  assign m_axis_tlast  = m_tlast_r;

  // Frame-length bookkeeping: the first word uses the live mode input, later
  // words use the mode latched with that first word.
  always_comb begin
    mode_eff_s = mode_r;
    if (word_cnt_r == '0) begin
      mode_eff_s = mode;
    end else begin
      mode_eff_s = mode_r;
    end
    wpf_s       = mode_eff_s ? WCW'(WPF_QAM) : WCW'(WPF_QPSK);
    last_word_s = (word_cnt_r == (wpf_s - WCW'(1)));
    last_sym_s  = (sym_cnt_r == SCW'(NSYM - 1));
    last_bin_s  = (out_idx_r == IDXW'(NFFT - 1));
  end

  // Symbol mapper: the next symbol always sits in the top bits of bits_r.
  always_comb begin
    sym_bits_s = bits_r[BUFW-1 -: 4];
    sym_i_s    = 16'd0;
    sym_q_s    = 16'd0;
    if (mode_r) begin
      sym_i_s = gray_level(sym_bits_s[3:2]);
      sym_q_s = gray_level(sym_bits_s[1:0]);
    end else begin
      sym_i_s = qpsk_level(sym_bits_s[3]);
      sym_q_s = qpsk_level(sym_bits_s[2]);
    end
    sym_qn_s   = 16'd0 - sym_q_s;
    sym_idx_s  = IDXW'(sym_cnt_r) + IDXW'(1);
    // NFFT - k computed modulo 2^IDXW (NFFT is a power of two).
    conj_idx_s = IDXW'(0) - sym_idx_s;
  end

  // Output lookahead: data for the bin that follows the current one.
  always_comb begin
    nxt_idx_s  = out_idx_r + IDXW'(1);
    bin_data_s = 32'd0;
    if ((nxt_idx_s == IDXW'(0)) || (nxt_idx_s == IDXW'(NFFT / 2))) begin
      bin_data_s = 32'd0;
    end else begin
      bin_data_s = mem_r[nxt_idx_s];
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = S_READ;
    case (state_r)
      S_READ: begin
        if (s_hs_s && last_word_s) begin
          state_nxt_s = S_MAP;
        end else begin
          state_nxt_s = S_READ;
        end
      end
      S_MAP: begin
        if (last_sym_s) begin
          state_nxt_s = S_WRITE;
        end else begin
          state_nxt_s = S_MAP;
        end
      end
      S_WRITE: begin
        if (m_hs_s && last_bin_s) begin
          state_nxt_s = S_READ;
        end else begin
          state_nxt_s = S_WRITE;
        end
      end
      default: state_nxt_s = S_READ;
    endcase
  end

  // State register, counters, input buffer and output registers.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_r    <= S_READ;
      word_cnt_r <= '0;
      mode_r     <= 1'b0;
      sym_cnt_r  <= '0;
      out_idx_r  <= '0;
      bits_r     <= '0;
      m_tdata_r  <= 32'd0;
      m_tvalid_r <= 1'b0;
      m_tlast_r  <= 1'b0;
    end else if (en) begin
      state_r <= state_nxt_s;
      case (state_r)
        S_READ: begin
          if (s_hs_s) begin
            if (word_cnt_r == '0) begin
              mode_r <= mode;
            end
            for (int w = 0; w < WPF_QAM; w++) begin
              if (word_cnt_r == WCW'(w)) begin
                bits_r[BUFW-1-32*w -: 32] <= s_axis_tdata;
              end
            end
            word_cnt_r <= last_word_s ? '0 : (word_cnt_r + WCW'(1));
            sym_cnt_r  <= '0;
          end
        end
        S_MAP: begin
          // Consume one symbol; surplus trailing bits are simply never used.
          bits_r    <= mode_r ? (bits_r << 4) : (bits_r << 2);
          sym_cnt_r <= sym_cnt_r + SCW'(1);
          if (last_sym_s) begin
            out_idx_r  <= '0;
            m_tdata_r  <= 32'd0;
            m_tlast_r  <= 1'b0;
            m_tvalid_r <= 1'b1;
          end
        end
        S_WRITE: begin
          if (m_hs_s) begin
            if (last_bin_s) begin
              out_idx_r  <= '0;
              m_tdata_r  <= 32'd0;
              m_tlast_r  <= 1'b0;
              m_tvalid_r <= 1'b0;
            end else begin
              out_idx_r <= nxt_idx_s;
              m_tdata_r <= bin_data_s;
              m_tlast_r <= (nxt_idx_s == IDXW'(NFFT - 1));
            end
          end
        end
        default: begin
          word_cnt_r <= '0;
          sym_cnt_r  <= '0;
          out_idx_r  <= '0;
          m_tvalid_r <= 1'b0;
          m_tlast_r  <= 1'b0;
        end
      endcase
    end
  end

  // Bin memory: symbol k and its conjugate at NFFT-k, one symbol per cycle.
  always_ff @(posedge aclk) begin
    if (en && (state_r == S_MAP)) begin
      mem_r[sym_idx_s]  <= {sym_i_s, sym_q_s};
      mem_r[conj_idx_s] <= {sym_i_s, sym_qn_s};
    end
  end

`ifdef AXIS_QAM_ERR_EN
  logic err_r;

  // Sticky framing error: tlast must be high exactly on the final frame word.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      err_r <= 1'b0;
    end else if (s_hs_s && (s_axis_tlast != last_word_s)) begin
      err_r <= 1'b1;
    end
  end

  assign err = err_r;
`else
  logic unused_tlast_s;

  assign unused_tlast_s = s_axis_tlast;
  assign err            = 1'b0;
`endif

endmodule
